// File: rtl/simon_loader_pkg.sv
// simon_loader_pkg: shared types and constants for the Simon byte loader
//   loader_state_t : FSM state encoding
//   KEY_BYTES / DATA_BYTES / CNT_W : sizes for the default N=32, M=2 build
//   TIMEOUT_LIMIT  : WAIT watchdog limit (used with SIMON_LOADER_TIMEOUT_EN)
package simon_loader_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, UNLOAD} loader_state_t;
   localparam int N_DEF = 32;
   localparam int M_DEF = 2;
   localparam int KEY_BYTES = N_DEF * M_DEF / 8;
   localparam int DATA_BYTES = N_DEF / 8;
   localparam int CNT_W = $clog2(DATA_BYTES + 1);
   localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;
endpackage

// File: rtl/simon_byte_loader_shift.sv
// byte_shift_reg: register that shifts in a byte on enable, with parallel load
//   clk, rst_n : clock, async active-low clear
//   shift      : shift q left by a byte, byte_in enters at the bottom
//   load, din  : parallel load (has priority over shift)
//   q          : register contents
module byte_shift_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift,
   input  logic             load,
   input  logic [7:0]       byte_in,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (load) q <= din;
      else if (shift) q <= {q[WIDTH-9:0], byte_in};
endmodule

// File: rtl/simon_byte_loader.sv
// simon_byte_loader: byte-serial key/plaintext loader and ciphertext unloader for Simon
//   byte_in, key_valid, data_valid : byte input and its key/plaintext strobes
//   byte_out, out_valid, out_ack   : ciphertext byte stream, MSB byte first
//   busy, error                    : activity flag, sticky timeout flag
//   cipher_key/pt/start            : drive the cipher core
//   cipher_ct/done                 : results from the cipher core
//   Macro SIMON_LOADER_TIMEOUT_EN enables the WAIT watchdog and error flag.
module simon_byte_loader
   import simon_loader_pkg::*;
#(
   parameter int N = 32,
   parameter int M = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [7:0]     byte_in,
   input  logic           key_valid,
   input  logic           data_valid,
   output logic [7:0]     byte_out,
   output logic           out_valid,
   input  logic           out_ack,
   output logic           busy,
   output logic           error,
   output logic [N*M-1:0] cipher_key,
   output logic [N-1:0]   cipher_pt,
   output logic           cipher_start,
   input  logic [N-1:0]   cipher_ct,
   input  logic           cipher_done
);
   localparam int DB = N / 8;
   localparam int CW = $clog2(DB + 1);
   loader_state_t state, state_n;
   logic [CW-1:0] dcnt, dcnt_n, ocnt, ocnt_n;
   logic          load_ok, key_en, data_en, ct_load, ct_shift, timeout;
   logic [N-1:0]  ct;
   assign load_ok = state == IDLE || state == LOAD;
   assign key_en = key_valid && load_ok;
   // a simultaneous key strobe wins; the data byte is dropped
   assign data_en = data_valid && !key_valid && load_ok;
   assign byte_out = ct[N-1:N-8];
   byte_shift_reg #(.WIDTH(N*M)) u_key (
      .clk(clk), .rst_n(rst_n), .shift(key_en), .load(1'b0),
      .byte_in(byte_in), .din('0), .q(cipher_key)
   );
   byte_shift_reg #(.WIDTH(N)) u_pt (
      .clk(clk), .rst_n(rst_n), .shift(data_en), .load(1'b0),
      .byte_in(byte_in), .din('0), .q(cipher_pt)
   );
   byte_shift_reg #(.WIDTH(N)) u_ct (
      .clk(clk), .rst_n(rst_n), .shift(ct_shift), .load(ct_load),
      .byte_in(8'd0), .din(cipher_ct), .q(ct)
   );
`ifdef SIMON_LOADER_TIMEOUT_EN
   logic [7:0] wdog;
   assign timeout = state == WAIT && !cipher_done && wdog == TIMEOUT_LIMIT - 8'd1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wdog  <= '0;
         error <= 1'b0;
      end else begin
         wdog  <= state == WAIT ? wdog + 8'd1 : 8'd0;
         error <= error | timeout;
      end
`else
   assign timeout = 1'b0;
   assign error = 1'b0;
`endif
   always_comb begin
      state_n  = state;
      dcnt_n   = dcnt;
      ocnt_n   = ocnt;
      ct_load  = 1'b0;
      ct_shift = 1'b0;
      case (state)
         IDLE, LOAD: if (data_en) begin
            dcnt_n  = dcnt == CW'(DB - 1) ? '0 : dcnt + 1'b1;
            state_n = dcnt == CW'(DB - 1) ? START : LOAD;
         end
         START: state_n = WAIT;
         WAIT: begin
            ct_load = cipher_done;
            state_n = cipher_done ? UNLOAD : timeout ? IDLE : WAIT;
            dcnt_n  = timeout ? '0 : dcnt;
         end
         UNLOAD: if (out_ack) begin
            ct_shift = 1'b1;
            ocnt_n   = ocnt == CW'(DB - 1) ? '0 : ocnt + 1'b1;
            state_n  = ocnt == CW'(DB - 1) ? IDLE : UNLOAD;
         end
         default: state_n = IDLE;
      endcase
   end
   // status outputs are registered from the next state so they align with it
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state        <= IDLE;
         dcnt         <= '0;
         ocnt         <= '0;
         cipher_start <= 1'b0;
         busy         <= 1'b0;
         out_valid    <= 1'b0;
      end else begin
         state        <= state_n;
         dcnt         <= dcnt_n;
         ocnt         <= ocnt_n;
         cipher_start <= state_n == START;
         busy         <= state_n == START || state_n == WAIT || state_n == UNLOAD;
         out_valid    <= state_n == UNLOAD;
      end
endmodule

// File: tb/tb_simon_byte_loader.sv
// tb_simon_byte_loader: directed plus randomized bench with a Simon 32/64 reference model
module tb_simon_byte_loader;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  byte_in = '0;
   logic        key_valid = 1'b0, data_valid = 1'b0, out_ack = 1'b0, cipher_done = 1'b0;
   logic [31:0] cipher_ct = '0;
   logic [7:0]  byte_out;
   logic        out_valid, busy, error, cipher_start;
   logic [63:0] cipher_key;
   logic [31:0] cipher_pt;
   int          total = 0, bad = 0, n = 0;
   logic [63:0] key_m = '0, rkey;
   logic [31:0] pt_m = '0, rpt;

   simon_byte_loader dut (
      .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .key_valid(key_valid),
      .data_valid(data_valid), .byte_out(byte_out), .out_valid(out_valid),
      .out_ack(out_ack), .busy(busy), .error(error), .cipher_key(cipher_key),
      .cipher_pt(cipher_pt), .cipher_start(cipher_start), .cipher_ct(cipher_ct),
      .cipher_done(cipher_done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] simon(input logic [63:0] key, input logic [31:0] pt);
      logic [15:0] k[32];
      logic [15:0] x, y, t;
      logic [61:0] z;
      z = 62'b11111010001001010110000111001101111101000100101011000011100110;
      for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
      for (int i = 4; i < 32; i++) begin
         t = {k[i-1][2:0], k[i-1][15:3]} ^ k[i-3];
         t = t ^ {t[0], t[15:1]};
         k[i] = ~k[i-4] ^ t ^ {15'd0, z[61-(i-4)]} ^ 16'd3;
      end
      x = pt[31:16];
      y = pt[15:0];
      for (int i = 0; i < 32; i++) begin
         t = x;
         x = y ^ ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]} ^ k[i];
         y = t;
      end
      return {x, y};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic k, input logic [7:0] b);
      byte_in = b;
      key_valid = k;
      data_valid = !k;
      tick;
      key_valid = 1'b0;
      data_valid = 1'b0;
      if (k) key_m = {key_m[55:0], b};
      else pt_m = {pt_m[23:0], b};
   endtask

   // loads a full key then four data bytes, optionally slipping a key byte into LOAD
   task automatic load_block(input logic [63:0] key, input logic [31:0] pt, input bit mid_key);
      for (int i = 0; i < 8; i++) begin
         send(1'b1, key[63-8*i -: 8]);
         repeat ($urandom_range(0, 1)) tick;
      end
      for (int i = 0; i < 4; i++) begin
         chk("no_early_start", cipher_start, 1'b0);
         send(1'b0, pt[31-8*i -: 8]);
         if (i == 1 && mid_key) send(1'b1, 8'($urandom));
         if (i < 3) repeat ($urandom_range(0, 2)) tick;
      end
   endtask

   task automatic run_block(input logic [31:0] exp, input int delay, input bit poke, input bit b2b);
      chk("start_hi", cipher_start, 1'b1);
      chk("busy_start", busy, 1'b1);
      chk("pt_out", cipher_pt, pt_m);
      chk("key_out", cipher_key, key_m);
      tick;
      chk("start_lo", cipher_start, 1'b0);
      repeat (delay) begin
         if (poke) begin
            byte_in = 8'($urandom);
            key_valid = 1'($urandom);
            data_valid = 1'($urandom);
            out_ack = 1'($urandom);
         end
         tick;
         key_valid = 1'b0;
         data_valid = 1'b0;
         out_ack = 1'b0;
      end
      chk("wait_key_stable", cipher_key, key_m);
      chk("wait_pt_stable", cipher_pt, pt_m);
      chk("wait_no_valid", out_valid, 1'b0);
      cipher_ct = simon(key_m, pt_m);
      cipher_done = 1'b1;
      tick;
      cipher_done = 1'b0;
      cipher_ct = '0;
      chk("capture_valid", out_valid, 1'b1);
      for (int b = 0; b < 4; b++) begin
         chk("byte_out", byte_out, exp[31-8*b -: 8]);
         chk("unload_valid", out_valid, 1'b1);
         out_ack = 1'b1;
         tick;
         if (!b2b) begin
            out_ack = 1'b0;
            if (b < 3) repeat ($urandom_range(0, 2)) begin
               chk("hold_byte", byte_out, exp[23-8*b -: 8]);
               tick;
            end
         end
      end
      out_ack = 1'b0;
      chk("done_valid", out_valid, 1'b0);
      chk("done_busy", busy, 1'b0);
   endtask

   initial begin
      repeat (2) tick;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_start", cipher_start, 1'b0);
      chk("rst_err", error, 1'b0);
      chk("rst_byte", byte_out, 8'h00);
      chk("rst_key", cipher_key, 64'h0);
      chk("rst_pt", cipher_pt, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick;

      // reference vector, with ignored strobes poked into WAIT
      load_block(64'h1918111009080100, 32'h65656877, 1'b0);
      chk("ref_pt", cipher_pt, 32'h65656877);
      chk("ref_key", cipher_key, 64'h1918111009080100);
      run_block(32'hc69be9bb, 3, 1'b1, 1'b0);

      // done and ack outside their states are ignored
      cipher_done = 1'b1;
      out_ack = 1'b1;
      tick;
      cipher_done = 1'b0;
      out_ack = 1'b0;
      chk("idle_done_valid", out_valid, 1'b0);
      chk("idle_done_busy", busy, 1'b0);

      // simultaneous strobes: key takes AA, data byte dropped
      send(1'b0, 8'h11);
      send(1'b0, 8'h22);
      byte_in = 8'hAA;
      key_valid = 1'b1;
      data_valid = 1'b1;
      tick;
      key_valid = 1'b0;
      data_valid = 1'b0;
      key_m = {key_m[55:0], 8'hAA};
      chk("sim_key", cipher_key, key_m);
      chk("sim_pt", cipher_pt, pt_m);
      send(1'b0, 8'h33);
      chk("sim_no_start", cipher_start, 1'b0);
      send(1'b0, 8'h44);
      chk("sim_pt_full", cipher_pt, 32'h11223344);
      run_block(simon(key_m, 32'h11223344), 2, 1'b0, 1'b1);

      // randomized blocks against the model
      for (int r = 0; r < 6; r++) begin
         rkey = {32'($urandom), 32'($urandom)};
         rpt = 32'($urandom);
         load_block(rkey, rpt, r[0]);
         run_block(simon(key_m, pt_m), $urandom_range(0, 6), 1'($urandom), r[1]);
      end

      // reset mid-load
      send(1'b0, 8'hDE);
      send(1'b0, 8'hAD);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_pt", cipher_pt, 32'h0);
      chk("mid_rst_key", cipher_key, 64'h0);
      chk("mid_rst_busy", busy, 1'b0);
      key_m = '0;
      pt_m = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick;
      for (int i = 0; i < 4; i++) begin
         chk("rst_no_start", cipher_start, 1'b0);
         send(1'b0, 8'(8'hC0 + i));
      end
      chk("rst_fresh_pt", cipher_pt, 32'hC0C1C2C3);
      run_block(simon(64'h0, 32'hC0C1C2C3), 1, 1'b0, 1'b1);

      // core never answers
      load_block(64'h0123456789ABCDEF, 32'h5A5A0F0F, 1'b0);
      chk("to_start", cipher_start, 1'b1);
      tick;
`ifdef SIMON_LOADER_TIMEOUT_EN
      while (busy && n < 1000) begin
         tick;
         n++;
      end
      chk("to_cycles", n, 255);
      chk("to_error", error, 1'b1);
      chk("to_valid", out_valid, 1'b0);
`else
      repeat (1000) tick;
      chk("to_still_busy", busy, 1'b1);
      chk("to_no_error", error, 1'b0);
      chk("to_valid", out_valid, 1'b0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
